// File: rtl/code_shift_buffer_if.sv
// Interface bundling the digit-entry controls and buffer status of code_shift_buffer.
// The master side enters digits and supplies the reference code; the slave is the buffer.
interface code_shift_buffer_if #(
    parameter int DIGIT_W = 4,
    parameter int DEPTH   = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                       push;
    logic                       pop;
    logic                       flush;
    logic [DIGIT_W-1:0]         digit_in;
    logic [DEPTH*DIGIT_W-1:0]   code_ref;
    logic [DEPTH*DIGIT_W-1:0]   data_o;
    logic [CW-1:0]              count;
    logic                       empty;
    logic                       full;
    logic                       overflow;
    logic                       match;

    modport master (
        output push, pop, flush, digit_in, code_ref,
        input  data_o, count, empty, full, overflow, match
    );

    modport slave (
        input  push, pop, flush, digit_in, code_ref,
        output data_o, count, empty, full, overflow, match
    );
endinterface

// File: rtl/code_shift_buffer.sv
// Keypad-style digit buffer: newest digit sits in the top slice, backspace removes it,
// and a full buffer can be compared against a reference code.
module code_shift_buffer #(
    parameter int DIGIT_W   = 4,
    parameter int DEPTH     = 4,
    parameter bit OVERWRITE = 1'b1
) (
    input logic               clk,
    input logic               clr,
    code_shift_buffer_if.slave bus
);
    localparam int W  = DEPTH * DIGIT_W;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  data_q;
    logic [CW-1:0] count_q;
    logic          overflow_q;
    logic          is_empty;
    logic          is_full;
    logic [W-1:0]  shift_in;
    logic [W-1:0]  shift_back;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == FULL_CNT);

    // Entering a digit ages everything toward slice 0; backspace moves it back and
    // zero-fills slice 0, which keeps every invalid slice at zero.
    assign shift_in   = {bus.digit_in, data_q[W-1:DIGIT_W]};
    assign shift_back = {data_q[W-DIGIT_W-1:0], {DIGIT_W{1'b0}}};

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            data_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= 1'b0;
            if (bus.flush) begin
                data_q  <= '0;
                count_q <= '0;
            end else if (bus.push && bus.pop && !is_empty) begin
                data_q[W-1 -: DIGIT_W] <= bus.digit_in;
            end else if (bus.push) begin
                if (is_full) begin
                    overflow_q <= 1'b1;
                    if (OVERWRITE) begin
                        data_q <= shift_in;
                    end
                end else begin
                    data_q  <= shift_in;
                    count_q <= count_q + 1'b1;
                end
            end else if (bus.pop && !is_empty) begin
                data_q  <= shift_back;
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign bus.data_o   = data_q;
    assign bus.count    = count_q;
    assign bus.empty    = is_empty;
    assign bus.full     = is_full;
    assign bus.overflow = overflow_q;
    assign bus.match    = is_full && (data_q == bus.code_ref);
endmodule

// File: tb/tb_code_shift_buffer.sv
// Self-checking bench for code_shift_buffer: an overwriting and a refusing instance run
// side by side against a digit-queue model through an expected-value scoreboard.
module tb_code_shift_buffer;
    typedef logic [3:0] dq_t[$];

    typedef struct packed {
        logic [15:0] d_ow;
        logic [15:0] d_nw;
        logic [2:0]  c_ow;
        logic [2:0]  c_nw;
        logic        o_ow;
        logic        o_nw;
        logic        m_ow;
        logic        m_nw;
    } exp_t;

    logic clk;
    logic clr;

    code_shift_buffer_if #(.DIGIT_W(4), .DEPTH(4)) bus_ow ();
    code_shift_buffer_if #(.DIGIT_W(4), .DEPTH(4)) bus_nw ();

    code_shift_buffer #(.DIGIT_W(4), .DEPTH(4), .OVERWRITE(1'b1)) dut_ow (
        .clk (clk),
        .clr (clr),
        .bus (bus_ow.slave)
    );

    code_shift_buffer #(.DIGIT_W(4), .DEPTH(4), .OVERWRITE(1'b0)) dut_nw (
        .clk (clk),
        .clr (clr),
        .bus (bus_nw.slave)
    );

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t sb[$];
    exp_t cur;
    dq_t  mq_ow;
    dq_t  mq_nw;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] pack_q(input dq_t q);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < q.size(); i++) r[(3-i)*4 +: 4] = q[q.size()-1-i];
        return r;
    endfunction

    task automatic model_apply(ref dq_t q, input bit ow, input bit p, input bit po,
                               input bit f, input logic [3:0] d, output logic ovf);
        ovf = 1'b0;
        if (f) q.delete();
        else if (p && po && q.size() > 0) q[q.size()-1] = d;
        else if (p) begin
            if (q.size() == 4) begin
                ovf = 1'b1;
                if (ow) begin
                    void'(q.pop_front());
                    q.push_back(d);
                end
            end else q.push_back(d);
        end else if (po && q.size() > 0) void'(q.pop_back());
    endtask

    task automatic set_ref(input logic [15:0] r);
        bus_ow.code_ref = r;
        bus_nw.code_ref = r;
    endtask

    task automatic drive(input bit p, input bit po, input bit f, input logic [3:0] d);
        bus_ow.push = p;  bus_ow.pop = po;  bus_ow.flush = f;  bus_ow.digit_in = d;
        bus_nw.push = p;  bus_nw.pop = po;  bus_nw.flush = f;  bus_nw.digit_in = d;
    endtask

    // One clocked operation: model both instances, queue expectations, drive, advance.
    task automatic step(input bit p, input bit po, input bit f, input logic [3:0] d);
        exp_t e;
        model_apply(mq_ow, 1'b1, p, po, f, d, e.o_ow);
        model_apply(mq_nw, 1'b0, p, po, f, d, e.o_nw);
        e.d_ow = pack_q(mq_ow);
        e.d_nw = pack_q(mq_nw);
        e.c_ow = 3'(mq_ow.size());
        e.c_nw = 3'(mq_nw.size());
        e.m_ow = (mq_ow.size() == 4) && (e.d_ow == bus_ow.code_ref);
        e.m_nw = (mq_nw.size() == 4) && (e.d_nw == bus_nw.code_ref);
        sb.push_back(e);
        drive(p, po, f, d);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 4'h0);
    endtask

    // Scoreboard consumer: compares just after each edge that had a queued operation.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            n_cmp += 12;
            if (bus_ow.data_o !== cur.d_ow) begin n_fail++; $display("FAIL data_ow: got %h want %h", bus_ow.data_o, cur.d_ow); end
            if (bus_nw.data_o !== cur.d_nw) begin n_fail++; $display("FAIL data_nw: got %h want %h", bus_nw.data_o, cur.d_nw); end
            if (bus_ow.count !== cur.c_ow) begin n_fail++; $display("FAIL count_ow: got %0d want %0d", bus_ow.count, cur.c_ow); end
            if (bus_nw.count !== cur.c_nw) begin n_fail++; $display("FAIL count_nw: got %0d want %0d", bus_nw.count, cur.c_nw); end
            if (bus_ow.overflow !== cur.o_ow) begin n_fail++; $display("FAIL overflow_ow: got %b want %b", bus_ow.overflow, cur.o_ow); end
            if (bus_nw.overflow !== cur.o_nw) begin n_fail++; $display("FAIL overflow_nw: got %b want %b", bus_nw.overflow, cur.o_nw); end
            if (bus_ow.empty !== (cur.c_ow == 3'd0)) begin n_fail++; $display("FAIL empty_ow: got %b count %0d", bus_ow.empty, cur.c_ow); end
            if (bus_nw.empty !== (cur.c_nw == 3'd0)) begin n_fail++; $display("FAIL empty_nw: got %b count %0d", bus_nw.empty, cur.c_nw); end
            if (bus_ow.full !== (cur.c_ow == 3'd4)) begin n_fail++; $display("FAIL full_ow: got %b count %0d", bus_ow.full, cur.c_ow); end
            if (bus_nw.full !== (cur.c_nw == 3'd4)) begin n_fail++; $display("FAIL full_nw: got %b count %0d", bus_nw.full, cur.c_nw); end
            if (bus_ow.match !== cur.m_ow) begin n_fail++; $display("FAIL match_ow: got %b want %b", bus_ow.match, cur.m_ow); end
            if (bus_nw.match !== cur.m_nw) begin n_fail++; $display("FAIL match_nw: got %b want %b", bus_nw.match, cur.m_nw); end
        end
    end

    task automatic check_reset_outputs(input string tag);
        n_cmp += 2;
        if ({bus_ow.data_o, bus_ow.count, bus_ow.overflow, bus_ow.empty, bus_ow.full, bus_ow.match} !== {16'h0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL %s_ow: got data %h count %0d ovf %b empty %b full %b match %b, want reset values",
                     tag, bus_ow.data_o, bus_ow.count, bus_ow.overflow, bus_ow.empty, bus_ow.full, bus_ow.match);
        end
        if ({bus_nw.data_o, bus_nw.count, bus_nw.overflow, bus_nw.empty, bus_nw.full, bus_nw.match} !== {16'h0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL %s_nw: got data %h count %0d ovf %b empty %b full %b match %b, want reset values",
                     tag, bus_nw.data_o, bus_nw.count, bus_nw.overflow, bus_nw.empty, bus_nw.full, bus_nw.match);
        end
    endtask

    task automatic test_reset();
        clr = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        set_ref(16'h0);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;
    endtask

    task automatic test_fill_match();
        step(1'b0, 1'b0, 1'b1, 4'h0);
        step(1'b1, 1'b0, 1'b0, 4'h1);
        step(1'b1, 1'b0, 1'b0, 4'h2);
        step(1'b1, 1'b0, 1'b0, 4'h3);
        set_ref(16'h3210);
        #1;
        n_cmp++;
        if (bus_ow.match !== 1'b0) begin n_fail++; $display("FAIL match_not_full: got %b want 0", bus_ow.match); end
        step(1'b1, 1'b0, 1'b0, 4'h4);
        set_ref(16'h4321);
        #1;
        n_cmp++;
        if (bus_ow.match !== 1'b1) begin n_fail++; $display("FAIL match_4321: got %b want 1", bus_ow.match); end
        set_ref(16'h1234);
        #1;
        n_cmp++;
        if (bus_ow.match !== 1'b0) begin n_fail++; $display("FAIL match_1234: got %b want 0", bus_ow.match); end
        set_ref(16'h0);
    endtask

    task automatic test_overflow();
        step(1'b1, 1'b0, 1'b0, 4'h5);
        step(1'b0, 1'b0, 1'b0, 4'h0);
        step(1'b1, 1'b1, 1'b0, 4'h6);
        step(1'b1, 1'b0, 1'b0, 4'h7);
        step(1'b1, 1'b0, 1'b1, 4'h8);
    endtask

    task automatic test_backspace();
        step(1'b1, 1'b0, 1'b0, 4'h7);
        step(1'b1, 1'b0, 1'b0, 4'h8);
        step(1'b0, 1'b1, 1'b0, 4'h0);
        step(1'b0, 1'b1, 1'b0, 4'h0);
        step(1'b0, 1'b1, 1'b0, 4'h0);
        step(1'b1, 1'b1, 1'b0, 4'h5);
        step(1'b0, 1'b0, 1'b1, 4'h0);
    endtask

    task automatic test_replace_flush();
        step(1'b1, 1'b0, 1'b0, 4'h1);
        step(1'b1, 1'b0, 1'b0, 4'h2);
        step(1'b1, 1'b0, 1'b0, 4'h3);
        step(1'b1, 1'b1, 1'b0, 4'h9);
        step(1'b1, 1'b0, 1'b1, 4'hF);
    endtask

    task automatic test_async_clear();
        step(1'b1, 1'b0, 1'b0, 4'h1);
        step(1'b1, 1'b0, 1'b0, 4'h2);
        #2 clr = 1'b0;
        #1 check_reset_outputs("clr_mid_cycle");
        mq_ow.delete();
        mq_nw.delete();
        @(negedge clk);
        clr = 1'b1;
        step(1'b1, 1'b0, 1'b0, 4'hA);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 4'(i + 1));
        // Refused/overwriting push, then clear while its overflow pulse is high.
        drive(1'b1, 1'b0, 1'b0, 4'hC);
        model_apply(mq_ow, 1'b1, 1'b1, 1'b0, 1'b0, 4'hC, cur.o_ow);
        @(posedge clk);
        #3;
        n_cmp++;
        if (bus_ow.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_pulse_before_clr: got %b want 1", bus_ow.overflow); end
        drive(1'b0, 1'b0, 1'b0, 4'h0);
        clr = 1'b0;
        #1 check_reset_outputs("clr_during_ovf");
        mq_ow.delete();
        mq_nw.delete();
        @(negedge clk);
        clr = 1'b1;
        step(1'b0, 1'b0, 1'b0, 4'h0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)));
        end
    endtask

    initial begin
        test_reset();
        test_fill_match();
        test_overflow();
        test_backspace();
        test_replace_flush();
        test_async_clear();
        test_random();
        repeat (2) @(negedge clk);
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
